// File: rtl/sar_adc_pkg.sv
// Shared types and parameter helpers for the 4-bit SAR ADC controller.
// Phase length covers DAC settling plus the two-flop comparator synchronizer.
package sar_adc_pkg;

    localparam int NBITS_DEF         = 4;
    localparam int SAMPLE_CYCLES_DEF = 4;
    localparam int SETTLE_CYCLES_DEF = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } sar_state_t;

    function automatic int sar_phase_len(input int settle_cycles);
        return settle_cycles + 2;
    endfunction

    // Counter must reach max(SAMPLE_CYCLES, PH)-1; never narrower than one bit.
    function automatic int sar_cnt_width(input int sample_cycles, input int phase_len);
        int m;
        m = (sample_cycles > phase_len) ? sample_cycles : phase_len;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sar_sync2.sv
// Two-flop synchronizer for a single asynchronous level; 2-cycle latency.
// Both stages clear to 0 on reset.
module sar_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR conversion controller: sample, then resolve one bit per PH-cycle phase, MSB first.
// valid_o lands 1+SAMPLE_CYCLES+NBITS*PH cycles after start_i; no backpressure, start_i ignored while busy.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int NBITS         = NBITS_DEF,
    parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             abort_i,
    input  logic             comp_i,
    output logic             sample_o,
    output logic [NBITS-1:0] dac_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [NBITS-1:0] data_o
);

    localparam int PH = sar_phase_len(SETTLE_CYCLES);
    localparam int CW = sar_cnt_width(SAMPLE_CYCLES, PH);
    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [CW-1:0]    SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0]    PH_LAST     = CW'(PH - 1);
    localparam logic [IW-1:0]    IDX_MSB     = IW'(NBITS - 1);
    localparam logic [NBITS-1:0] MSB_ONE     = NBITS'(1) << (NBITS - 1);

    sar_state_t       r_state;
    sar_state_t       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [IW-1:0]    r_idx;
    logic [IW-1:0]    w_idx_nxt;
    logic [NBITS-1:0] r_dac;
    logic [NBITS-1:0] w_dac_nxt;
    logic [NBITS-1:0] r_data;
    logic [NBITS-1:0] w_data_nxt;

    logic             w_comp_sync;
    logic [NBITS-1:0] w_bit_mask;
    logic [NBITS-1:0] w_resolved;

    sar_sync2 u_comp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (comp_i),
        .o_q   (w_comp_sync)
    );

    // Trial bit survives only if the comparator says Vin >= Vdac.
    assign w_bit_mask = NBITS'(1) << r_idx;
    assign w_resolved = w_comp_sync ? r_dac : (r_dac & ~w_bit_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dac   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_dac   <= w_dac_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_dac_nxt   = r_dac;
        w_data_nxt  = r_data;

        case (r_state)
            IDLE: begin
                if (start_i && !abort_i) begin
                    w_state_nxt = SAMPLE;
                    w_cnt_nxt   = '0;
                    w_dac_nxt   = '0;
                end
            end
            SAMPLE: begin
                if (r_cnt == SAMPLE_LAST) begin
                    w_state_nxt = CONVERT;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = IDX_MSB;
                    w_dac_nxt   = MSB_ONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            CONVERT: begin
                if (r_cnt == PH_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_idx == '0) begin
                        w_state_nxt = DONE;
                        w_dac_nxt   = w_resolved;
                        w_data_nxt  = w_resolved;
                    end else begin
                        w_idx_nxt = r_idx - 1'b1;
                        w_dac_nxt = w_resolved | (w_bit_mask >> 1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = cont_i ? SAMPLE : IDLE;
                w_cnt_nxt   = '0;
                w_dac_nxt   = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_dac_nxt   = '0;
            end
        endcase

        // Abort wins over every transition above and never touches the held result.
        if (abort_i && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_dac_nxt   = '0;
            w_data_nxt  = r_data;
        end
    end

    assign sample_o = (r_state == SAMPLE);
    assign busy_o   = (r_state == SAMPLE) || (r_state == CONVERT);
    assign valid_o  = (r_state == DONE);
    assign dac_o    = r_dac;
    assign data_o   = r_data;

    a_valid_not_busy : assert property (@(posedge clk) disable iff (!rst_n) valid_o |-> !busy_o);
    a_sample_dac_zero : assert property (@(posedge clk) disable iff (!rst_n) sample_o |-> (dac_o == '0));

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl with a comparator model that settles within one cycle of dac_o.
// Per-cycle traces are recorded #1 after each rising edge, index 0 being the cycle after start_i is sampled.
module tb_sar_adc_ctrl;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start_i = 1'b0;
    logic       cont_i  = 1'b0;
    logic       abort_i = 1'b0;
    logic       comp_i  = 1'b0;
    logic       sample_o;
    logic [3:0] dac_o;
    logic       busy_o;
    logic       valid_o;
    logic [3:0] data_o;

    logic [3:0] vin_code = 4'd0;

    int errors = 0;
    int checks = 0;

    logic [3:0] tr_dac  [0:63];
    logic [3:0] tr_data [0:63];
    logic       tr_smp  [0:63];
    logic       tr_busy [0:63];
    logic       tr_vld  [0:63];

    sar_adc_ctrl #(
        .NBITS         (4),
        .SAMPLE_CYCLES (4),
        .SETTLE_CYCLES (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .cont_i   (cont_i),
        .abort_i  (abort_i),
        .comp_i   (comp_i),
        .sample_o (sample_o),
        .dac_o    (dac_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .data_o   (data_o)
    );

    always #5 clk = ~clk;

    // Comparator responds to the DAC code half a cycle after it changes.
    always @(negedge clk) comp_i <= (vin_code >= dac_o);

    task automatic rec(input int n);
        tr_dac[n]  = dac_o;
        tr_data[n] = data_o;
        tr_smp[n]  = sample_o;
        tr_busy[n] = busy_o;
        tr_vld[n]  = valid_o;
    endtask

    task automatic step(input int n);
        @(posedge clk);
        #1;
        rec(n);
    endtask

    task automatic kick();
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        rec(0);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({sample_o, busy_o, valid_o, dac_o, data_o} !== 11'd0) begin
            errors++;
            $display("FAIL reset_async outputs=%b required=0", {sample_o, busy_o, valid_o, dac_o, data_o});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sample_o, busy_o, valid_o, dac_o, data_o} !== 11'd0) begin
            errors++;
            $display("FAIL reset_clocked outputs=%b required=0", {sample_o, busy_o, valid_o, dac_o, data_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(0);
        checks++;
        if ({sample_o, busy_o, valid_o, dac_o} !== 7'd0) begin
            errors++;
            $display("FAIL reset_release_idle outputs=%b required=0", {sample_o, busy_o, valid_o, dac_o});
        end
    endtask

    // trials holds the four expected DAC trial codes, MSB phase in the top nibble.
    task automatic test_conversion(input string name, input logic [3:0] vin,
                                   input logic [15:0] trials, input logic [3:0] exp_code);
        logic [3:0] exp_dac;
        int         nsmp;
        vin_code = vin;
        kick();
        for (int n = 1; n <= 18; n++) step(n);
        nsmp = 0;
        for (int n = 0; n <= 18; n++) begin
            nsmp += int'(tr_smp[n]);
            if (n < 4)       exp_dac = 4'd0;
            else if (n < 16) exp_dac = trials[15 - 4 * ((n - 4) / 3) -: 4];
            else if (n == 16) exp_dac = exp_code;
            else             exp_dac = 4'd0;
            checks++;
            if (tr_dac[n] !== exp_dac) begin
                errors++;
                $display("FAIL %s dac cycle %0d got=%0d want=%0d", name, n, tr_dac[n], exp_dac);
            end
            checks++;
            if ({tr_smp[n], tr_busy[n], tr_vld[n]} !== {n < 4, n < 16, n == 16}) begin
                errors++;
                $display("FAIL %s smp/busy/vld cycle %0d got=%b want=%b", name, n,
                         {tr_smp[n], tr_busy[n], tr_vld[n]}, {n < 4, n < 16, n == 16});
            end
        end
        checks++;
        if (nsmp !== 4) begin
            errors++;
            $display("FAIL %s sample_cycles got=%0d want=4", name, nsmp);
        end
        checks++;
        if (tr_data[16] !== exp_code || tr_data[18] !== exp_code) begin
            errors++;
            $display("FAIL %s data got=%0d/%0d want=%0d", name, tr_data[16], tr_data[18], exp_code);
        end
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        start_i = 1'b1;
        abort_i = 1'b1;
        step(0);
        start_i = 1'b0;
        abort_i = 1'b0;
        step(1);
        step(2);
        checks++;
        if ({tr_smp[0], tr_busy[0], tr_smp[2], tr_busy[2], tr_vld[2]} !== 5'b0) begin
            errors++;
            $display("FAIL start_abort_idle got=%b want=0",
                     {tr_smp[0], tr_busy[0], tr_smp[2], tr_busy[2], tr_vld[2]});
        end
    endtask

    task automatic test_start_ignored();
        int nvld;
        int nbusy;
        vin_code = 4'd5;
        kick();
        for (int n = 1; n <= 40; n++) begin
            start_i = (n == 7) || (n == 12);
            step(n);
        end
        start_i = 1'b0;
        nvld  = 0;
        nbusy = 0;
        for (int n = 0; n <= 40; n++) nvld += int'(tr_vld[n]);
        for (int n = 17; n <= 40; n++) nbusy += int'(tr_busy[n]);
        checks++;
        if (nvld !== 1 || tr_vld[16] !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored valid_count got=%0d want=1 (at cycle 16)", nvld);
        end
        checks++;
        if (tr_data[16] !== 4'd5) begin
            errors++;
            $display("FAIL start_ignored data got=%0d want=5", tr_data[16]);
        end
        checks++;
        if (nbusy !== 0) begin
            errors++;
            $display("FAIL start_ignored extra_conversion busy_cycles got=%0d want=0", nbusy);
        end
    endtask

    task automatic test_continuous();
        int nvld;
        cont_i   = 1'b1;
        vin_code = 4'd3;
        kick();
        for (int n = 1; n <= 45; n++) begin
            if (n == 17) vin_code = 4'd9;
            if (n == 18) cont_i = 1'b0;
            step(n);
        end
        nvld = 0;
        for (int n = 0; n <= 45; n++) nvld += int'(tr_vld[n]);
        checks++;
        if (nvld !== 2 || tr_vld[16] !== 1'b1 || tr_vld[33] !== 1'b1) begin
            errors++;
            $display("FAIL cont valid_pattern count=%0d v16=%b v33=%b want 2,1,1", nvld, tr_vld[16], tr_vld[33]);
        end
        checks++;
        if (tr_data[16] !== 4'd3) begin
            errors++;
            $display("FAIL cont first_data got=%0d want=3", tr_data[16]);
        end
        checks++;
        if (tr_data[33] !== 4'd9) begin
            errors++;
            $display("FAIL cont second_data got=%0d want=9", tr_data[33]);
        end
        checks++;
        if ({tr_smp[17], tr_busy[17]} !== 2'b11) begin
            errors++;
            $display("FAIL cont restart got=%b want=11", {tr_smp[17], tr_busy[17]});
        end
        checks++;
        if ({tr_smp[34], tr_busy[34], tr_dac[34]} !== 6'd0) begin
            errors++;
            $display("FAIL cont stop_idle got=%b want=0", {tr_smp[34], tr_busy[34], tr_dac[34]});
        end
    endtask

    task automatic test_abort(input logic [3:0] prev_code);
        int nvld;
        vin_code = 4'd14;
        kick();
        for (int n = 1; n <= 25; n++) begin
            abort_i = (n == 8);
            step(n);
        end
        abort_i = 1'b0;
        nvld = 0;
        for (int n = 0; n <= 25; n++) nvld += int'(tr_vld[n]);
        checks++;
        if (tr_busy[7] !== 1'b1 || tr_dac[7] !== 4'd12) begin
            errors++;
            $display("FAIL abort pre busy=%b dac=%0d want busy=1 dac=12", tr_busy[7], tr_dac[7]);
        end
        checks++;
        if ({tr_busy[8], tr_smp[8], tr_dac[8]} !== 6'd0) begin
            errors++;
            $display("FAIL abort idle_next got=%b want=0", {tr_busy[8], tr_smp[8], tr_dac[8]});
        end
        checks++;
        if (nvld !== 0) begin
            errors++;
            $display("FAIL abort valid_count got=%0d want=0", nvld);
        end
        checks++;
        if (tr_data[25] !== prev_code) begin
            errors++;
            $display("FAIL abort data_held got=%0d want=%0d", tr_data[25], prev_code);
        end
    endtask

    task automatic test_reset_mid();
        vin_code = 4'd6;
        kick();
        step(1);
        step(2);
        checks++;
        if (tr_smp[2] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid in_sample got=%b want=1", tr_smp[2]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sample_o, busy_o, valid_o, dac_o, data_o} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid async_clear outputs=%b required=0", {sample_o, busy_o, valid_o, dac_o, data_o});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_conversion("vin11", 4'd11, 16'h8CAB, 4'd11);
        test_conversion("vin15", 4'd15, 16'h8CEF, 4'd15);
        test_conversion("vin0",  4'd0,  16'h8421, 4'd0);
        test_start_abort_idle();
        test_start_ignored();
        test_continuous();
        test_abort(4'd9);
        test_reset_mid();
        test_conversion("after_reset", 4'd6, 16'h8467, 4'd6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
